// File: rtl/denormalize_frac_seq.sv
// Sequential right-shift alignment of a fraction, one bit per cycle,
// with guard/round/sticky collection and a valid/ready handshake.
module denormalize_frac_seq #(
  parameter int FRAC_W = 24,
  parameter int SH_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W-1:0] frac_in,
  input  logic [SH_W-1:0]   shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W-1:0] frac_out,
  output logic              guard,
  output logic              round,
  output logic              sticky
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  // Shifting by FRAC_W+2 or more pushes every bit of W into sticky.
  localparam logic [SH_W:0] SAT_AMT = (SH_W+1)'(FRAC_W + 2);

  logic [1:0]        state_r, state_nxt;
  logic [FRAC_W+1:0] w_r, w_nxt;
  logic              sticky_r, sticky_nxt;
  logic [SH_W-1:0]   n_r, n_nxt;

  logic [FRAC_W-1:0] frac_out_r;
  logic              guard_r, round_r, sticky_out_r;

  // Next-state and datapath for the shift sequencer.
  always_comb begin
    state_nxt  = state_r;
    w_nxt      = w_r;
    sticky_nxt = sticky_r;
    n_nxt      = n_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          n_nxt = shamt;
          if ({1'b0, shamt} >= SAT_AMT) begin
            w_nxt      = '0;
            sticky_nxt = |frac_in;
            state_nxt  = DONE;
          end else begin
            w_nxt      = {frac_in, 2'b00};
            sticky_nxt = 1'b0;
            if (shamt == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt = SHIFT;
            end
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        w_nxt      = w_r >> 1;
        sticky_nxt = sticky_r | w_r[0];
        n_nxt      = n_r - SH_W'(1);
        if (n_r == SH_W'(1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Working state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      w_r      <= '0;
      sticky_r <= 1'b0;
      n_r      <= '0;
    end else begin
      state_r  <= state_nxt;
      w_r      <= w_nxt;
      sticky_r <= sticky_nxt;
      n_r      <= n_nxt;
    end
  end

  // Result registers only change on entry to DONE, hiding partial shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_out_r   <= '0;
      guard_r      <= 1'b0;
      round_r      <= 1'b0;
      sticky_out_r <= 1'b0;
    end else if ((state_nxt == DONE) && (state_r != DONE)) begin
      frac_out_r   <= w_nxt[FRAC_W+1:2];
      guard_r      <= w_nxt[1];
      round_r      <= w_nxt[0];
      sticky_out_r <= sticky_nxt;
    end else begin
      frac_out_r   <= frac_out_r;
      guard_r      <= guard_r;
      round_r      <= round_r;
      sticky_out_r <= sticky_out_r;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign frac_out  = frac_out_r;
  assign guard     = guard_r;
  assign round     = round_r;
  assign sticky    = sticky_out_r;

endmodule

// File: doc/denormalize_frac_seq.md
DENORMALIZE_FRAC_SEQ -- requirements
Module: denormalize_frac_seq

Interface
Parameters:
REQ-001 The block SHALL have parameter FRAC_W, default 24, the fraction width including the hidden bit.
REQ-002 The block SHALL have parameter SH_W, default 8, the shift-amount width (exponent difference).
Ports:
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 The block SHALL have port in_valid  input  1  request valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port frac_in  input  FRAC_W  fraction to be aligned.
REQ-008 The block SHALL have port shamt  input  SH_W  unsigned right-shift amount.
REQ-009 The block SHALL have port out_valid  output  1  result valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 The block SHALL have port frac_out  output  FRAC_W  right-aligned fraction.
REQ-012 The block SHALL have ports guard, round, sticky  output  1 each  the first, second and OR-of-remaining bits shifted out.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 A request SHALL be accepted on an edge where state=IDLE and in_valid=1; inputs are sampled only at that edge.
REQ-016 On acceptance, the block SHALL load a working register W of FRAC_W+2 bits = {frac_in, 2'b00}, clear sticky, and load counter n = shamt.
REQ-017 If shamt=0, the block SHALL go IDLE->DONE, so out_valid rises 1 cycle after acceptance.
REQ-018 If shamt >= FRAC_W+2, the block SHALL saturate: go IDLE->DONE with W=0 and sticky = OR(frac_in), with 1-cycle latency.
REQ-019 Otherwise the block SHALL go IDLE->SHIFT.
REQ-020 Each SHIFT cycle SHALL perform W <= W>>1, sticky <= sticky | W[0], and n <= n-1.
REQ-021 SHIFT SHALL go to DONE on the edge where n transitions 1->0, so out_valid rises shamt+1 cycles after acceptance.
REQ-022 Outputs SHALL be: frac_out = W[FRAC_W+1:2], guard = W[1], round = W[0], plus the registered sticky.
REQ-023 In DONE, all outputs SHALL hold stable while out_ready=0.
REQ-024 DONE->IDLE SHALL occur on an edge with out_ready=1; in_ready is 1 the following cycle (no same-cycle turnaround).
REQ-025 in_valid and input changes outside IDLE SHALL be ignored.
REQ-026 frac_out, guard, round and sticky SHALL be undefined-free: they are 0 or the last result while out_valid=0.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, W=0, sticky=0, n=0; out_valid=0, frac_out=0, guard=round=sticky=0, in_ready=1.
REQ-028 A reset asserted during SHIFT or DONE SHALL abort the operation with no result emitted; the first edge after release may accept a new request.

Verification
REQ-029 The bench SHALL cover: frac_in=0xC00000, shamt=0 -> out_valid 1 cycle after acceptance, frac_out=0xC00000, g=r=s=0.
REQ-030 The bench SHALL cover: frac_in=0x800001, shamt=3 -> out_valid 4 cycles after acceptance, frac_out=0x100000, g=0, r=0, s=1.
REQ-031 The bench SHALL cover: frac_in=0x800000, shamt=25 -> out_valid 26 cycles after acceptance, frac_out=0, g=0, r=1, s=0.
REQ-032 The bench SHALL cover: frac_in=0xFFFFFF, shamt=30 (saturation) -> out_valid 1 cycle after acceptance, frac_out=0, g=r=0, s=1.
REQ-033 The bench SHALL cover: a result held with out_ready=0 for 5 cycles -> outputs constant and in_ready=0 throughout; in_ready=1 one cycle after out_ready=1.
REQ-034 The bench SHALL cover: rst_n pulsed low mid-SHIFT (shamt=20, cycle 5) -> out_valid stays 0 and in_ready=1 immediately; a new request shamt=0 then completes normally.
